multu_hilo_unit: RTL and testbench

Sequential 32x32 unsigned shift-add multiplier with HI/LO result registers. It is the consumer of the 6-bit multiplier control code that the ALU control unit produces.
- While the code holds MULTU, the block iterates.
- It writes HI/LO only when the control unit issues the OPEN_HILO code (6'b111111) on the 32nd cycle.
- It drives HI or LO back to the datapath for MFHI/MFLO.
- It sits beside the ALU and shifter, and its output feeds the result mux.

---
 rtl/mips_ctrl_pkg.sv | 18 +
 rtl/hilo_reg.sv | 32 +++
 rtl/multu_hilo_unit.sv | 112 +++++++++++
 tb/tb_multu_hilo_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control constants: funct codes, the HI/LO commit code,
// operand width and the multiplier state encoding.
package mips_ctrl_pkg;
  localparam int WIDTH = 32;

  localparam logic [5:0] MULTU     = 6'b011001;
  localparam logic [5:0] MFHI      = 6'b010000;
  localparam logic [5:0] MFLO      = 6'b010010;
  localparam logic [5:0] AND       = 6'b100100;
  localparam logic [5:0] OR        = 6'b100101;
  localparam logic [5:0] ADD       = 6'b100000;
  localparam logic [5:0] SUB       = 6'b100010;
  localparam logic [5:0] SLT       = 6'b101010;
  localparam logic [5:0] SRL       = 6'b000010;
  localparam logic [5:0] OPEN_HILO = 6'b111111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/hilo_reg.sv
// HI/LO result pair with write enable and the MFHI/MFLO read mux.
module hilo_reg
  import mips_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_we,
  input  logic [W-1:0] i_hi,
  input  logic [W-1:0] i_lo,
  input  logic [5:0]   i_sel,
  output logic [W-1:0] o_rd
);
  logic [W-1:0] r_hi, r_lo;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_we) begin
      r_hi <= i_hi;
      r_lo <= i_lo;
    end
  end

  always_comb begin
    o_rd = '0;
    if (i_sel == MFHI)      o_rd = r_hi;
    else if (i_sel == MFLO) o_rd = r_lo;
  end
endmodule

// File: rtl/multu_hilo_unit.sv
// Sequential unsigned shift-add multiplier. One radix-2 step per MULTU edge;
// the OPEN_HILO edge performs the last step and commits the product to HI/LO.
module multu_hilo_unit
  import mips_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             err
);
  localparam int SW = $clog2(WIDTH) + 1;

  state_t             r_state, w_state_nxt;
  logic [SW-1:0]      r_step, w_step_nxt;
  logic [WIDTH-1:0]   r_mcand, w_mcand_nxt, w_m;
  logic [2*WIDTH-1:0] r_prod, w_prod_nxt, w_p, w_p_step;
  logic [WIDTH:0]     w_sum;
  logic               r_err, w_err_nxt, w_we;
  logic               w_last;

  // In IDLE the first step works straight off the operand inputs.
  assign w_m = (r_state == IDLE) ? dataA : r_mcand;
  assign w_p = (r_state == IDLE) ? {{WIDTH{1'b0}}, dataB} : r_prod;

  // Carry out of the add lands in the top bit after the shift, so nothing is lost.
  always_comb begin
    w_sum    = {1'b0, w_p[2*WIDTH-1:WIDTH]} + {1'b0, (w_p[0] ? w_m : {WIDTH{1'b0}})};
    w_p_step = {w_sum, w_p[WIDTH-1:1]};
  end

  assign w_last = (r_step == SW'(WIDTH-1));

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_mcand_nxt = r_mcand;
    w_prod_nxt  = r_prod;
    w_err_nxt   = 1'b0;
    w_we        = 1'b0;
    case (r_state)
      IDLE: begin
        if (Signal == MULTU) begin
          w_mcand_nxt = dataA;
          w_prod_nxt  = w_p_step;
          w_step_nxt  = SW'(1);
          w_state_nxt = RUN;
        end else if (Signal == OPEN_HILO) begin
          w_err_nxt = 1'b1;
        end
      end
      RUN: begin
        if (Signal == MULTU) begin
          if (w_last) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_prod_nxt = w_p_step;
            w_step_nxt = r_step + SW'(1);
          end
        end else if (Signal == OPEN_HILO) begin
          if (w_last) begin
            w_we        = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DONE: begin
        // The control unit may keep MULTU asserted; only a different code releases us.
        if (Signal != MULTU && Signal != OPEN_HILO) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_mcand <= w_mcand_nxt;
      r_prod  <= w_prod_nxt;
      r_err   <= w_err_nxt;
    end
  end

  hilo_reg #(.W(WIDTH)) u_hilo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_we    (w_we),
    .i_hi    (w_p_step[2*WIDTH-1:WIDTH]),
    .i_lo    (w_p_step[WIDTH-1:0]),
    .i_sel   (Signal),
    .o_rd    (dataOut)
  );

  assign busy = (r_state == RUN);
  assign err  = r_err;
endmodule

// File: tb/tb_multu_hilo_unit.sv
// Scoreboard bench: the driver predicts each cycle's outputs from a
// protocol-level model using plain 64-bit multiplication; the monitor checks.
module tb_multu_hilo_unit;
  import mips_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Signal;
  logic [31:0] dataA, dataB, dataOut;
  logic        busy, err;

  multu_hilo_unit dut (
    .clk(clk), .reset(reset), .Signal(Signal), .dataA(dataA), .dataB(dataB),
    .dataOut(dataOut), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        b;
    logic        e;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: 0=idle 1=running 2=done; m_cnt = multiply edges taken.
  int          m_state = 0;
  int          m_cnt   = 0;
  logic [31:0] m_a = 0, m_b = 0, m_hi = 0, m_lo = 0;
  logic        m_err = 0;

  task automatic model_edge(input logic [5:0] sig, input logic rn,
                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (!rn) begin
      m_state = 0; m_cnt = 0; m_hi = 0; m_lo = 0; m_err = 0;
      return;
    end
    m_err = 0;
    case (m_state)
      0: if (sig == MULTU) begin
           m_a = a; m_b = b; m_cnt = 1; m_state = 1;
         end else if (sig == OPEN_HILO) m_err = 1;
      1: if (sig == MULTU) begin
           if (m_cnt >= 31) begin m_err = 1; m_state = 0; end
           else m_cnt++;
         end else if (sig == OPEN_HILO) begin
           if (m_cnt == 31) begin
             p = {32'd0, m_a} * {32'd0, m_b};
             m_hi = p[63:32]; m_lo = p[31:0]; m_state = 2;
           end else begin m_err = 1; m_state = 0; end
         end else m_state = 0;
      default: if (sig != MULTU && sig != OPEN_HILO) m_state = 0;
    endcase
  endtask

  task automatic cyc(input logic [5:0] sig, input logic rn = 1'b1,
                     input logic [31:0] a = $urandom, input logic [31:0] b = $urandom);
    exp_t x;
    Signal = sig; reset = rn; dataA = a; dataB = b;
    x.d = (sig == MFHI) ? m_hi : (sig == MFLO) ? m_lo : 32'd0;
    x.b = (m_state == 1);
    x.e = m_err;
    q.push_back(x);
    model_edge(sig, rn, a, b);
    @(posedge clk); #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled mid-cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        check("dataOut", dataOut, x.d);
        check("busy", {31'd0, busy}, {31'd0, x.b});
        check("err", {31'd0, err}, {31'd0, x.e});
      end
    end
  end

  // n MULTU edges (operands on the first), then OPEN_HILO, then reads.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input int n);
    cyc(MULTU, 1'b1, a, b);
    for (int i = 1; i < n; i++) cyc(MULTU);
    cyc(OPEN_HILO);
    cyc(MFLO);
    cyc(MFHI);
  endtask

  initial begin
    logic [5:0] codes [5];
    codes[0] = MULTU; codes[1] = OPEN_HILO; codes[2] = MFHI; codes[3] = MFLO; codes[4] = ADD;
    reset = 1'b0; Signal = ADD; dataA = '0; dataB = '0;
    @(posedge clk); #1;
    cyc(ADD, 1'b0); cyc(MFHI, 1'b0);
    cyc(MFLO);

    run(32'd3, 32'd5, 31);
    run(32'hFFFFFFFF, 32'hFFFFFFFF, 31);

    // Post-commit: MULTU held through a second OPEN_HILO at edge 64.
    cyc(MULTU, 1'b1, 32'd9, 32'd9);
    for (int i = 1; i < 31; i++) cyc(MULTU);
    cyc(OPEN_HILO);
    for (int i = 0; i < 31; i++) cyc(MULTU);
    cyc(OPEN_HILO);
    for (int i = 0; i < 8; i++) cyc(MULTU);
    cyc(ADD); cyc(MFHI); cyc(MFLO);

    run(32'd11, 32'd13, 10);   // early commit -> err, HI/LO kept
    cyc(MFLO);
    run(32'hDEADBEEF, 32'h01234567, 31);
    run(32'd4, 32'd4, 32);     // one step too many -> err
    cyc(OPEN_HILO);            // commit code while idle -> err

    run(32'h2468ACF0, 32'h80000000, 31);
    cyc(MULTU, 1'b1, 32'd1, 32'd1);
    for (int i = 1; i < 20; i++) cyc(MULTU);
    cyc(MULTU, 1'b0);
    cyc(MFHI); cyc(MFLO);
    run(32'd7, 32'd6, 31);

    for (int r = 0; r < 12; r++) begin
      int n;
      n = (r % 3 == 0) ? $urandom_range(1, 33) : 31;
      cyc(MULTU, 1'b1, $urandom, $urandom);
      for (int i = 1; i < n; i++) begin
        if ($urandom_range(0, 99) == 0) cyc(codes[$urandom_range(2, 4)]);
        else cyc(MULTU);
      end
      cyc(OPEN_HILO);
      for (int i = 0; i < 4; i++) cyc(codes[$urandom_range(0, 4)]);
      cyc(MFLO); cyc(MFHI); cyc(ADD);
    end

    @(negedge clk); #1;
    check("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
